// File: rtl/vga_render_pkg.sv
// Shared constants and helpers for the Game-of-Life pixel back-end.
package vga_render_pkg;

  // 8x8 cell icon, one byte per row; bit index = sub-column.
  localparam logic [7:0] ICON_ROWS [8] = '{
    8'h00, 8'h3C, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h3C, 8'h00
  };

  // RGB222 colours packed as {R[1:0], G[1:0], B[1:0]}.
  localparam logic [5:0] COL_BLANK  = 6'b00_00_00;
  localparam logic [5:0] COL_BORDER = 6'b00_00_01;
  localparam logic [5:0] COL_DEAD   = 6'b01_01_01;
  localparam logic [5:0] COL_LIVE   = 6'b11_11_01;
  localparam logic [5:0] COL_CURSOR = 6'b11_00_00;

  // Build the TinyTapeout VGA byte {hs,B0,G0,R0,vs,B1,G1,R1}.
  function automatic logic [7:0] pack_tt_vga(input logic hs, input logic vs,
                                             input logic [5:0] rgb);
    logic [1:0] r, g, b;
    r = rgb[5:4];
    g = rgb[3:2];
    b = rgb[1:0];
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Frame-edge detector and cursor blink timer.
// frame_start_o pulses one cycle after vsync_i enters its active level;
// blink_phase_o toggles every BLINK_FRAMES frame_start pulses.
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 15,
  parameter int VSYNC_ACTIVE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic frame_start_o,
  output logic blink_phase_o
);

  localparam logic       VS_ACT   = 1'(VSYNC_ACTIVE);
  localparam logic [5:0] CNT_LAST = 6'(BLINK_FRAMES - 1);

  logic       vs_prev_q;
  logic       frame_start_q, frame_start_d;
  logic [5:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  // Edge detect and blink counter next-state.
  always_comb begin
    frame_start_d = (vsync_i == VS_ACT) && (vs_prev_q != VS_ACT);
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    if (frame_start_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = 6'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev_q     <= 1'b0;
      frame_start_q <= 1'b0;
      cnt_q         <= 6'd0;
      phase_q       <= 1'b0;
    end else begin
      vs_prev_q     <= vsync_i;
      frame_start_q <= frame_start_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
    end
  end

  assign frame_start_o = frame_start_q;
  assign blink_phase_o = phase_q;

endmodule

// File: rtl/vga_cell_renderer.sv
// Pixel back-end: board address generation, cell icon, window framing,
// blinking cursor, and a registered TT VGA output byte.
// Pipeline: stage 0 drives cell_addr combinationally, stage 1 registers the
// pixel context while the board memory answers, stage 2 registers uo_out.
// Syncs travel the same two registers as colour, so they stay aligned.
module vga_cell_renderer
  import vga_render_pkg::*;
#(
  parameter int LOG_W        = 3,
  parameter int LOG_H        = 4,
  parameter int X0           = 64,
  parameter int X1           = 576,
  parameter int Y0           = 48,
  parameter int Y1           = 432,
  parameter int BLINK_FRAMES = 15,
  parameter int VSYNC_ACTIVE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   display_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic [LOG_W+LOG_H-1:0] cell_addr,
  input  logic                   cell_data,
  input  logic [LOG_W-1:0]       cursor_x,
  input  logic [LOG_H-1:0]       cursor_y,
  input  logic                   cursor_en,
  output logic [7:0]             uo_out,
  output logic                   frame_start
);

  // Only the low bits of the window-relative position are ever used; the
  // low bits of a modular difference equal the difference of the low bits.
  localparam logic [LOG_W+2:0] X0_LO = (LOG_W+3)'(X0);
  localparam logic [LOG_H+2:0] Y0_LO = (LOG_H+3)'(Y0);

  // Stage 0 (combinational).
  logic [LOG_W+2:0] rx_d;
  logic [LOG_H+2:0] ry_d;
  logic [LOG_W-1:0] cell_x_d;
  logic [LOG_H-1:0] cell_y_d;
  logic             in_win_d;

  // Stage 1 registers.
  logic             in_win_q, disp_q, hs_q, vs_q;
  logic [2:0]       sub_x_q, sub_y_q;
  logic [LOG_W-1:0] cell_x_q;
  logic [LOG_H-1:0] cell_y_q;

  // Colour and stage 2.
  logic             blink_phase;
  logic             cursor_hit;
  logic             icon_bit;
  logic [5:0]       rgb_d;
  logic [7:0]       uo_d, uo_q;

  assign rx_d      = hpos[LOG_W+2:0] - X0_LO;
  assign ry_d      = vpos[LOG_H+2:0] - Y0_LO;
  assign cell_x_d  = rx_d[LOG_W+2:3];
  assign cell_y_d  = ry_d[LOG_H+2:3];
  assign cell_addr = {cell_y_d, cell_x_d};
  assign in_win_d  = (hpos >= 10'(X0)) && (hpos < 10'(X1)) &&
                     (vpos >= 10'(Y0)) && (vpos < 10'(Y1));

  // Stage 1: capture pixel context alongside the board read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_win_q <= 1'b0;
      disp_q   <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      sub_x_q  <= 3'd0;
      sub_y_q  <= 3'd0;
      cell_x_q <= '0;
      cell_y_q <= '0;
    end else begin
      in_win_q <= in_win_d;
      disp_q   <= display_on;
      hs_q     <= hsync_in;
      vs_q     <= vsync_in;
      sub_x_q  <= rx_d[2:0];
      sub_y_q  <= ry_d[2:0];
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
    end
  end

  vga_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .VSYNC_ACTIVE (VSYNC_ACTIVE)
  ) u_blink (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync_i       (vsync_in),
    .frame_start_o (frame_start),
    .blink_phase_o (blink_phase)
  );

  assign cursor_hit = cursor_en && blink_phase &&
                      (cell_x_q == cursor_x) && (cell_y_q == cursor_y) &&
                      ((sub_x_q == 3'd0) || (sub_x_q == 3'd7) ||
                       (sub_y_q == 3'd0) || (sub_y_q == 3'd7));
  assign icon_bit   = ICON_ROWS[sub_y_q][sub_x_q];

  // Colour priority: blanking, border, cursor, live icon, dead background.
  always_comb begin
    rgb_d = COL_DEAD;
    if (!disp_q) begin
      rgb_d = COL_BLANK;
    end else if (!in_win_q) begin
      rgb_d = COL_BORDER;
    end else if (cursor_hit) begin
      rgb_d = COL_CURSOR;
    end else if (cell_data && icon_bit) begin
      rgb_d = COL_LIVE;
    end
    uo_d = pack_tt_vga(hs_q, vs_q, rgb_d);
  end

  // Stage 2: registered output byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_q <= 8'h00;
    end else begin
      uo_q <= uo_d;
    end
  end

  assign uo_out = uo_q;

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Self-checking bench for vga_cell_renderer: pixel stimulus pushes expected
// uo_out bytes into a queue; a monitor pops them two cycles later.
module tb_vga_cell_renderer;

  localparam int LOG_W = 3;
  localparam int LOG_H = 4;

  // Clock and DUT signals.
  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [9:0]             hpos, vpos;
  logic                   display_on, hsync_in, vsync_in;
  logic [LOG_W+LOG_H-1:0] cell_addr;
  logic                   cell_data = 1'b0;
  logic [LOG_W-1:0]       cursor_x;
  logic [LOG_H-1:0]       cursor_y;
  logic                   cursor_en;
  logic [7:0]             uo_out;
  logic                   frame_start;

  always #5 clk = ~clk;

  vga_cell_renderer #(
    .LOG_W        (LOG_W),
    .LOG_H        (LOG_H),
    .X0           (64),
    .X1           (576),
    .Y0           (48),
    .Y1           (432),
    .BLINK_FRAMES (2),
    .VSYNC_ACTIVE (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .cell_addr   (cell_addr),
    .cell_data   (cell_data),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .cursor_en   (cursor_en),
    .uo_out      (uo_out),
    .frame_start (frame_start)
  );

  // Board memory with one-cycle read latency.
  logic board [0:127];
  always @(posedge clk) cell_data <= board[cell_addr];

  // Scoreboard state.
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         fs_cnt   = 0;
  int         frames   = 0;
  logic       stim_valid = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;

  logic [7:0] icon [8] = '{8'h00, 8'h3C, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h3C, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Valid tracker: a pixel driven before edge N is on uo_out after edge N+1.
  always @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= stim_valid;
      v2 <= v1;
    end
  end

  always @(posedge clk) if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;

  // Monitor: pop and compare whenever a driven pixel reaches the output.
  always @(posedge clk) begin
    #1;
    if (v2) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        check("uo_out", {24'd0, uo_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic phase_now();
    return ((frames / 2) % 2) == 1;
  endfunction

  // Reference colour model.
  function automatic logic [7:0] model(input logic [9:0] h, input logic [9:0] v,
                                       input logic don, input logic hs, input logic vs);
    logic [9:0] rx, ry;
    logic [2:0] cx, sx, sy;
    logic [3:0] cy;
    logic       inw, curs;
    logic [1:0] r, g, b;
    rx   = h - 10'd64;
    ry   = v - 10'd48;
    cx   = rx[5:3];
    cy   = ry[6:3];
    sx   = rx[2:0];
    sy   = ry[2:0];
    inw  = (h >= 10'd64) && (h < 10'd576) && (v >= 10'd48) && (v < 10'd432);
    curs = cursor_en && phase_now() && (cx == cursor_x) && (cy == cursor_y) &&
           (sx == 3'd0 || sx == 3'd7 || sy == 3'd0 || sy == 3'd7);
    if (!don)                              {r, g, b} = 6'b00_00_00;
    else if (!inw)                         {r, g, b} = 6'b00_00_01;
    else if (curs)                         {r, g, b} = 6'b11_00_00;
    else if (board[{cy, cx}] && icon[sy][sx]) {r, g, b} = 6'b11_11_01;
    else                                   {r, g, b} = 6'b01_01_01;
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // Driver tasks.
  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic don,
                       input logic hs, input logic vs, input logic [7:0] exp);
    @(negedge clk);
    hpos = h; vpos = v; display_on = don; hsync_in = hs; vsync_in = vs;
    stim_valid = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stim_valid = 1'b0;
    end
  endtask

  task automatic check_addr(input logic [9:0] h, input logic [9:0] v, input logic [6:0] exp);
    @(negedge clk);
    stim_valid = 1'b0;
    hpos = h; vpos = v;
    #1;
    check("cell_addr", {25'd0, cell_addr}, {25'd0, exp});
  endtask

  task automatic do_frame();
    @(negedge clk);
    stim_valid = 1'b0;
    vsync_in = 1'b0;
    @(posedge clk); #1;
    check("frame_start_pulse", {31'd0, frame_start}, 32'd1);
    @(posedge clk); #1;
    check("frame_start_single", {31'd0, frame_start}, 32'd0);
    repeat (8) @(negedge clk);
    vsync_in = 1'b1;
    repeat (10) @(negedge clk);
    frames++;
  endtask

  // Cursor cell (2,3) is live; neighbour (3,3) is dead.
  task automatic cursor_probe();
    logic ph;
    ph = phase_now() && cursor_en;
    drive(10'd80, 10'd75, 1'b1, 1'b0, 1'b1, ph ? 8'h19 : 8'h78);
    drive(10'd83, 10'd75, 1'b1, 1'b0, 1'b1, 8'h7B);
    drive(10'd87, 10'd79, 1'b1, 1'b0, 1'b1, ph ? 8'h19 : 8'h78);
    drive(10'd88, 10'd75, 1'b1, 1'b0, 1'b1, 8'h78);
    idle(3);
  endtask

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       don;
    logic       hs;
    logic [7:0] exp;
  } vec_t;

  // Hand-computed vectors, vsync idle high.
  vec_t vecs [15] = '{
    '{10'd64,  10'd48,  1'b1, 1'b0, 8'h78},  // live cell, icon corner off
    '{10'd67,  10'd51,  1'b1, 1'b0, 8'h7B},  // live cell, icon on
    '{10'd131, 10'd179, 1'b1, 1'b0, 8'h7B},  // tiled wrap back to cell 0
    '{10'd75,  10'd51,  1'b1, 1'b0, 8'h78},  // dead cell interior
    '{10'd10,  10'd100, 1'b1, 1'b0, 8'h48},  // border
    '{10'd10,  10'd100, 1'b0, 1'b0, 8'h08},  // blanked
    '{10'd10,  10'd100, 1'b0, 1'b1, 8'h88},  // blanked, hsync high
    '{10'd63,  10'd100, 1'b1, 1'b0, 8'h48},  // left edge outside
    '{10'd64,  10'd100, 1'b1, 1'b0, 8'h78},  // left edge inside
    '{10'd575, 10'd100, 1'b1, 1'b0, 8'h78},  // right edge inside
    '{10'd576, 10'd100, 1'b1, 1'b0, 8'h48},  // right edge outside
    '{10'd100, 10'd47,  1'b1, 1'b0, 8'h48},  // top edge outside
    '{10'd100, 10'd431, 1'b1, 1'b0, 8'h78},  // bottom edge inside
    '{10'd100, 10'd432, 1'b1, 1'b0, 8'h48},  // bottom edge outside
    '{10'd67,  10'd51,  1'b1, 1'b1, 8'hFB}   // live with hsync high
  };

  // Watchdog.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    for (int i = 0; i < 128; i++) board[i] = 1'b0;
    board[0]  = 1'b1;
    board[26] = 1'b1;
    rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0; display_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b1;
    cursor_x = 3'd2; cursor_y = 4'd3; cursor_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Mid-line reset discards in-flight pixels.
    for (int h = 100; h < 104; h++)
      drive(10'(h), 10'd100, 1'b1, 1'b0, 1'b1, model(10'(h), 10'd100, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    stim_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_uo_out", {24'd0, uo_out}, 32'd0);
      check("reset_frame_start", {31'd0, frame_start}, 32'd0);
    end
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    hpos = 10'd67; vpos = 10'd51; display_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
    stim_valid = 1'b1;
    exp_q.push_back(8'h7B);
    @(posedge clk); #1;
    check("post_reset_latency", {24'd0, uo_out}, 32'd0);
    idle(3);

    // Address generation and tiling wrap.
    check_addr(10'd64, 10'd48, 7'd0);
    check_addr(10'd131, 10'd179, 7'd0);
    check_addr(10'd81, 10'd74, 7'd26);

    // Directed colour vectors.
    foreach (vecs[i]) drive(vecs[i].h, vecs[i].v, vecs[i].don, vecs[i].hs, 1'b1, vecs[i].exp);
    idle(3);

    // Full-line sweep on row 100 with an hsync pulse.
    for (int h = 0; h < 640; h++) begin
      logic hs;
      hs = (h >= 600) && (h < 610);
      drive(10'(h), 10'd100, 1'b1, hs, 1'b1, model(10'(h), 10'd100, 1'b1, hs, 1'b1));
    end
    idle(3);

    // Frames and cursor blink.
    cursor_en = 1'b1;
    for (int f = 0; f <= 6; f++) begin
      cursor_probe();
      if (f < 6) do_frame();
    end
    cursor_en = 1'b0;
    cursor_probe();

    check("frame_start_count", fs_cnt, 32'd6);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
